// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the loopback UART (UART_PARITY_EN adds an even parity bit)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // start + 8 data + optional parity + stop
    localparam int   FRAME_BITS  = 10 + PARITY_BITS;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - synchroniser, centre sampler and receive FSM (UART_PARITY_EN adds parity check and rx_err)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line,
    output logic                 ready,
    output logic [DATA_BITS-1:0] dout
`ifdef UART_PARITY_EN
    ,
    output logic                 rx_err
`endif
);

    localparam int              PAY_BITS  = DATA_BITS + PARITY_BITS;
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      PAY_LAST  = 4'(PAY_BITS - 1);

    logic                 sync1, sync2;
    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           bit_idx, bit_n;
    logic [PAY_BITS-1:0]  shift, shift_n;
    logic                 ready_n;
    logic [DATA_BITS-1:0] dout_n;
    logic                 frame_ok;
`ifdef UART_PARITY_EN
    logic                 err_n;
`endif

`ifdef UART_PARITY_EN
    assign frame_ok = (sync2 == IDLE_LEVEL) && !(^shift);
`else
    assign frame_ok = (sync2 == IDLE_LEVEL);
`endif

    // Two-flop synchroniser on the loopback line, idle high out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
        end
    end

    // RX state, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            ready   <= 1'b0;
            dout    <= '0;
`ifdef UART_PARITY_EN
            rx_err  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            ready   <= ready_n;
            dout    <= dout_n;
`ifdef UART_PARITY_EN
            rx_err  <= err_n;
`endif
        end
    end

    // Next-state: qualify start at half a bit, then sample every bit centre
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        ready_n = 1'b0;
        dout_n  = dout;
`ifdef UART_PARITY_EN
        err_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sync2 == START_LEVEL) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = (sync2 == START_LEVEL) ? DATA : IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {sync2, shift[PAY_BITS-1:1]};
                    if (bit_idx == PAY_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (frame_ok) begin
                        ready_n = 1'b1;
                        dout_n  = shift[DATA_BITS-1:0];
                    end
`ifdef UART_PARITY_EN
                    else begin
                        err_n = 1'b1;
                    end
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_loopback.sv
// rtl/uart_loopback.sv - UART transmitter looped back into uart_rx (UART_PARITY_EN selects 8E1 framing and rx_err)
module uart_loopback
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 tx_busy,
    output logic                 ready,
    output logic [DATA_BITS-1:0] dout
`ifdef UART_PARITY_EN
    ,
    output logic                 rx_err
`endif
);

    localparam int            PAY_BITS = DATA_BITS + PARITY_BITS;
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    PAY_LAST = 4'(PAY_BITS - 1);

    uart_state_t         state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [3:0]          bit_idx, bit_n;
    logic [PAY_BITS-1:0] shift, shift_n;
    logic [PAY_BITS-1:0] load_word;
    logic                tx_line, line_n;

    // Parity rides along as the last payload bit so DATA handles it unchanged
`ifdef UART_PARITY_EN
    assign load_word = {even_parity(din), din};
`else
    assign load_word = din;
`endif

    // Busy is exactly "not idle", so a write can only land in IDLE
    assign tx_busy = (state != IDLE);

    // TX state, counters, shift register and registered serial line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_line <= IDLE_LEVEL;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx_line <= line_n;
        end
    end

    // Next-state and next line level: each frame bit is held CLKS_PER_BIT cycles
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        line_n  = IDLE_LEVEL;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    shift_n = load_word;
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == PAY_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            START:   line_n = START_LEVEL;
            DATA:    line_n = shift_n[0];
            default: line_n = IDLE_LEVEL;
        endcase
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_rx (
        .clk   (clk),
        .reset (reset),
        .line  (tx_line),
        .ready (ready),
        .dout  (dout)
`ifdef UART_PARITY_EN
        ,
        .rx_err(rx_err)
`endif
    );

endmodule

// File: tb/tb_uart_loopback.sv
// tb/tb_uart_loopback.sv - directed self-checking bench for uart_loopback
module tb_uart_loopback;

`ifdef UART_PARITY_EN
    localparam int BUSY_CYC = 176;
    localparam int LAT      = 171;
`else
    localparam int BUSY_CYC = 160;
    localparam int LAT      = 155;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       wr_en;
    logic       tx_busy;
    logic       ready;
    logic [7:0] dout;
`ifdef UART_PARITY_EN
    logic       rx_err;
    int         err_cnt = 0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rx_byte[$];
    int         rx_cyc[$];
    int         acc_cyc[$];
    int         busy_rise = 0;
    int         busy_fall = 0;
    int         dbl_ready = 0;
    int         stray_dout = 0;
    int         seen_c3 = 0;
    logic       prev_ready = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    uart_loopback #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .wr_en  (wr_en),
        .tx_busy(tx_busy),
        .ready  (ready),
        .dout   (dout)
`ifdef UART_PARITY_EN
        ,
        .rx_err (rx_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b0;
            prev_busy  = 1'b0;
            prev_dout  = dout;
        end else begin
            if (ready) begin
                rx_byte.push_back(dout);
                rx_cyc.push_back(cyc);
                if (prev_ready) dbl_ready++;
            end
            if (dout !== prev_dout && !ready) stray_dout++;
            if (dout === 8'hC3) seen_c3++;
            if (tx_busy && !prev_busy) begin
                busy_rise = cyc;
                acc_cyc.push_back(cyc);
            end
            if (!tx_busy && prev_busy) busy_fall = cyc;
`ifdef UART_PARITY_EN
            if (rx_err) err_cnt++;
`endif
            prev_ready = ready;
            prev_busy  = tx_busy;
            prev_dout  = dout;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (tx_busy !== 1'b0 && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_idle_timeout", 32'(k < 2000), 32'd1);
    endtask

    // Call at negedge+1; the write lands on the next rising edge n
    task automatic send(input logic [7:0] b, output int n);
        wait_idle();
        din   = b;
        wr_en = 1'b1;
        n     = cyc + 1;
        @(negedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_bytes(input int count, input int budget);
        int k = 0;
        while (rx_byte.size() < count && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_bytes_timeout", 32'(rx_byte.size()), 32'(count));
    endtask

    initial begin
        int         n;
        int         seen;
        int         k;
        logic [7:0] corner[4];
        corner = '{8'h00, 8'hFF, 8'h01, 8'h80};

        reset = 1'b1;
        wr_en = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  32'(tx_busy), 32'd0);
        check("rst_ready", 32'(ready),   32'd0);
        check("rst_dout",  32'(dout),    32'h00);
        reset = 1'b0;
        @(negedge clk); #1;

        // Reset in the middle of a frame
        send(8'hA5, n);
        repeat (50) @(negedge clk);
        #1;
        check("mid_busy_before", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy",  32'(tx_busy), 32'd0);
        check("mid_rst_ready", 32'(ready),   32'd0);
        check("mid_rst_dout",  32'(dout),    32'h00);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        check("mid_rst_no_ready", 32'(rx_byte.size()), 32'd0);

        // Single byte: busy length and ready latency
        rx_byte.delete(); rx_cyc.delete();
        send(8'h55, n);
        wait_bytes(1, 400);
        check("single_data", 32'(rx_byte[0]), 32'h55);
        check("single_lat",  32'(rx_cyc[0] - n), 32'(LAT));
        check("busy_rise",   32'(busy_rise - n), 32'd0);
        repeat (30) @(negedge clk);
        #1;
        check("busy_len", 32'(busy_fall - busy_rise), 32'(BUSY_CYC));

        // Corner bytes in order
        rx_byte.delete(); rx_cyc.delete();
        for (int i = 0; i < 4; i++) send(corner[i], n);
        wait_bytes(4, 1000);
        for (int i = 0; i < 4; i++)
            check($sformatf("corner_%0d", i), 32'(rx_byte[i]), 32'(corner[i]));

        // Write attempt while busy is ignored
        wait_idle();
        repeat (40) @(negedge clk);
        #1;
        rx_byte.delete(); rx_cyc.delete();
        seen_c3 = 0;
        send(8'h3C, n);
        repeat (20) @(negedge clk);
        #1;
        din   = 8'hC3;
        wr_en = 1'b1;
        @(negedge clk); #1;
        wr_en = 1'b0;
        wait_bytes(1, 400);
        repeat (200) @(negedge clk);
        #1;
        check("rej_count", 32'(rx_byte.size()), 32'd1);
        check("rej_data",  32'(rx_byte[0]),     32'h3C);
        check("rej_no_c3", 32'(seen_c3),        32'd0);

        // Back-to-back with wr_en held high
        wait_idle();
        rx_byte.delete(); rx_cyc.delete(); acc_cyc.delete();
        seen  = 0;
        k     = 0;
        din   = 8'h10;
        wr_en = 1'b1;
        while (seen < 3 && k < 2000) begin
            @(negedge clk); #1;
            k++;
            if (acc_cyc.size() != seen) begin
                seen = acc_cyc.size();
                din  = 8'(8'h10 + seen);
                if (seen >= 3) wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        check("b2b_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(BUSY_CYC + 1));
        check("b2b_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(BUSY_CYC + 1));
        wait_bytes(3, 600);
        check("b2b_data_0", 32'(rx_byte[0]), 32'h10);
        check("b2b_data_1", 32'(rx_byte[1]), 32'h11);
        check("b2b_data_2", 32'(rx_byte[2]), 32'h12);
        check("b2b_lat_2",  32'(rx_cyc[2] - acc_cyc[2]), 32'(LAT));

        repeat (50) @(negedge clk);
        #1;
        check("ready_single_cycle", 32'(dbl_ready),  32'd0);
        check("dout_only_on_ready", 32'(stray_dout), 32'd0);
`ifdef UART_PARITY_EN
        check("rx_err_quiet", 32'(err_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
